// File: rtl/level_ctrl_if.sv
// Bundle of game-progress signals between level_ctrl and the map lookup,
// ball physics and render blocks.
interface level_ctrl_if;
    logic        frame_tick;
    logic        start;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic        ball_fall;
    logic [10:0] score_x;
    logic [10:0] score_y;
    logic [10:0] init_x;
    logic [10:0] init_y;
    logic [1:0]  map;
    logic        spawn_valid;
    logic [10:0] spawn_x;
    logic [10:0] spawn_y;
    logic        playing;
    logic        level_done;
    logic        game_over;
    logic [7:0]  falls;
    logic [15:0] level_time;

    modport master (
        input  frame_tick, start, ball_x, ball_y, ball_fall,
               score_x, score_y, init_x, init_y,
        output map, spawn_valid, spawn_x, spawn_y, playing,
               level_done, game_over, falls, level_time
    );

    modport slave (
        output frame_tick, start, ball_x, ball_y, ball_fall,
               score_x, score_y, init_x, init_y,
        input  map, spawn_valid, spawn_x, spawn_y, playing,
               level_done, game_over, falls, level_time
    );
endinterface

// File: rtl/level_ctrl.sv
// Game-progress controller: spawns the ball, counts a sustained in-zone hold,
// respawns on fall and walks the maps through to game over.
module level_ctrl #(
    parameter int MAP_COUNT  = 2,
    parameter int HIT_RADIUS = 16,
    parameter int HOLD_TICKS = 30
) (
    input logic          clk,
    input logic          rst,
    level_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, SPAWN, PLAY, ADVANCE, DONE} state_t;

    localparam logic [1:0]  LAST_MAP  = 2'(MAP_COUNT - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [11:0] RADIUS    = 12'(HIT_RADIUS);

    state_t      state;
    logic [7:0]  hit_cnt;
    logic [1:0]  map;
    logic        spawn_valid, playing, level_done, game_over;
    logic [10:0] spawn_x, spawn_y;
    logic [7:0]  falls;
    logic [15:0] level_time;
    logic [11:0] dx, dy;
    logic        in_zone;

    // Magnitudes taken larger-minus-smaller so nothing wraps near the screen edge.
    always_comb begin
        dx = (bus.ball_x >= bus.score_x) ? {1'b0, bus.ball_x} - {1'b0, bus.score_x}
                                         : {1'b0, bus.score_x} - {1'b0, bus.ball_x};
        dy = (bus.ball_y >= bus.score_y) ? {1'b0, bus.ball_y} - {1'b0, bus.score_y}
                                         : {1'b0, bus.score_y} - {1'b0, bus.ball_y};
        in_zone = (dx <= RADIUS) && (dy <= RADIUS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            map         <= '0;
            spawn_x     <= '0;
            spawn_y     <= '0;
            spawn_valid <= 1'b0;
            level_done  <= 1'b0;
            playing     <= 1'b0;
            game_over   <= 1'b0;
            falls       <= '0;
            level_time  <= '0;
            hit_cnt     <= '0;
        end else begin
            spawn_valid <= 1'b0;
            level_done  <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    map   <= '0;
                    falls <= '0;
                    state <= SPAWN;
                end
                // map settled last cycle, so init_x/y already belong to it
                SPAWN: begin
                    spawn_x     <= bus.init_x;
                    spawn_y     <= bus.init_y;
                    spawn_valid <= 1'b1;
                    hit_cnt     <= '0;
                    level_time  <= '0;
                    playing     <= 1'b1;
                    state       <= PLAY;
                end
                PLAY: if (bus.ball_fall) begin
                    if (falls != 8'hFF) falls <= falls + 8'd1;
                    hit_cnt <= '0;
                    playing <= 1'b0;
                    state   <= SPAWN;
                end else if (bus.frame_tick) begin
                    if (level_time != 16'hFFFF) level_time <= level_time + 16'd1;
                    if (!in_zone) begin
                        hit_cnt <= '0;
                    end else if (hit_cnt == HOLD_LAST) begin
                        hit_cnt <= '0;
                        playing <= 1'b0;
                        state   <= ADVANCE;
                    end else begin
                        hit_cnt <= hit_cnt + 8'd1;
                    end
                end
                ADVANCE: begin
                    level_done <= 1'b1;
                    if (map == LAST_MAP) begin
                        game_over <= 1'b1;
                        state     <= DONE;
                    end else begin
                        map   <= map + 2'd1;
                        state <= SPAWN;
                    end
                end
                DONE: if (bus.start) begin
                    map       <= '0;
                    falls     <= '0;
                    game_over <= 1'b0;
                    state     <= SPAWN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.map         = map;
    assign bus.spawn_valid = spawn_valid;
    assign bus.spawn_x     = spawn_x;
    assign bus.spawn_y     = spawn_y;
    assign bus.playing     = playing;
    assign bus.level_done  = level_done;
    assign bus.game_over   = game_over;
    assign bus.falls       = falls;
    assign bus.level_time  = level_time;
endmodule
